// File: rtl/data_memory_port.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_port
// Description : Byte-addressable little-endian data memory with a valid/ready
//               request port, RISC-V sized loads/stores and a registered response.
// Revision    : 1.0
// ============================================================================
module data_memory_port #(
    parameter int    DEPTH_BYTES  = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int         c_AW          = $clog2(DEPTH_BYTES);
    localparam logic [1:0] c_BUSY_CYCLES = 2'(READ_LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_count;
    logic [31:0] r_pipe_data;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic            w_accept;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_fault;
    logic [31:0]     w_size;
    logic [3:0]      w_lane_en;
    logic [c_AW-1:0] w_base;
    logic [c_AW-1:0] w_idx  [4];
    logic [7:0]      w_byte [4];
    logic [31:0]     w_load_data;

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    assign w_is_byte = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
    assign w_is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    assign w_is_word = (req_funct3 == 3'b010);

    assign w_size    = w_is_word ? 32'd4 : (w_is_half ? 32'd2 : 32'd1);
    assign w_lane_en = w_is_word ? 4'b1111 : (w_is_half ? 4'b0011 : 4'b0001);

    // Unsigned BU/HU encodings have no store counterpart.
    assign w_illegal      = !(w_is_byte || w_is_half || w_is_word) || (req_write && req_funct3[2]);
    assign w_misaligned   = (w_is_half && req_address[0]) || (w_is_word && (req_address[1:0] != 2'b00));
    assign w_out_of_range = req_address > (32'(DEPTH_BYTES) - w_size);
    assign w_fault        = w_illegal || w_misaligned || w_out_of_range;

    assign w_base = req_address[c_AW-1:0];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_idx[k]  = w_base + c_AW'(k);
            assign w_byte[k] = r_mem[w_idx[k]];
        end
    endgenerate

    always_comb begin
        w_load_data = 32'd0;
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_byte[0][7]}}, w_byte[0]};
            3'b001:  w_load_data = {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
            3'b010:  w_load_data = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
            3'b100:  w_load_data = {24'd0, w_byte[0]};
            3'b101:  w_load_data = {16'd0, w_byte[1], w_byte[0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // Memory array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_accept && req_write && !w_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane_en[k]) begin
                    r_mem[w_idx[k]] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= 2'd0;
            r_pipe_data <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_error   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_error <= 1'b1;
                        end else if (req_write) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_error <= 1'b0;
                        end else if (READ_LATENCY == 1) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_load_data;
                            rsp_error <= 1'b0;
                        end else begin
                            // Capture now so later stores cannot alter an in-flight load.
                            r_pipe_data <= w_load_data;
                            r_count     <= c_BUSY_CYCLES;
                            r_state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_count == 2'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_pipe_data;
                        rsp_error <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_memory_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_port
// Description : Directed plus randomized bench for data_memory_port against a
//               byte-array reference model.
// Revision    : 1.0
// ============================================================================
module tb_data_memory_port;
    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model [DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;
    logic [31:0] saved;

    always #5 clk = ~clk;

    data_memory_port #(
        .DEPTH_BYTES (DEPTH),
        .READ_LATENCY(LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_address(req_address),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_faults(input bit w, input logic [31:0] a, input logic [2:0] f3);
        int sz = access_size(f3);
        if (sz == 0) return 1'b1;
        if (w && f3[2]) return 1'b1;
        if ((longint'(a) % sz) != 0) return 1'b1;
        if (longint'(a) > longint'(DEPTH - sz)) return 1'b1;
        return 1'b0;
    endfunction

    // Little-endian value of the accessed bytes, then two's-complement adjust for signed loads.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int     sz = access_size(f3);
        longint v  = 0;
        for (int i = 0; i < sz; i++) v += longint'(model[int'(a) + i]) * (longint'(1) << (8 * i));
        if (!f3[2] && sz < 4 && model[int'(a) + sz - 1][7]) v -= (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        int          sz;
        exp_err  = model_faults(w, a, f3);
        exp_data = (exp_err || w) ? 32'd0 : model_load(a, f3);
        exp_lat  = (exp_err || w) ? 1 : LAT;
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_wdata   = d;
        req_funct3  = f3;
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            check("ready_while_busy", {31'd0, req_ready}, 32'd0);
            // A legal store offered while busy must be ignored.
            req_valid   = 1'b1;
            req_write   = 1'b1;
            req_address = 32'($urandom_range(0, DEPTH / 4 - 1)) * 4;
            req_wdata   = $urandom;
            req_funct3  = 3'b010;
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        check("latency", lat, exp_lat);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        check("rsp_rdata", rsp_rdata, exp_data);
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
        @(negedge clk);
        check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        if (w && !exp_err) begin
            sz = access_size(f3);
            for (int i = 0; i < sz; i++) model[int'(a) + i] = d[8*i +: 8];
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = 32'd0;
        req_wdata   = 32'd0;
        req_funct3  = 3'b000;
        last_rdata  = 32'd0;
        last_err    = 1'b0;

        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            check("reset_valid", {31'd0, rsp_valid}, 32'd0);
            check("reset_ready", {31'd0, req_ready}, 32'd0);
        end
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        check("rdata_after_reset", rsp_rdata, 32'd0);
        check("error_after_reset", {31'd0, rsp_error}, 32'd0);
        @(negedge clk);

        // Give every byte a known value.
        for (int a = 0; a < DEPTH; a += 4) xact(1'b1, 32'(a), $urandom, 3'b010);

        // Byte stores assembled into a word.
        xact(1'b1, 32'd4, 32'h12ABCDEF, 3'b000);
        xact(1'b1, 32'd5, 32'h34FBDEAD, 3'b000);
        xact(1'b1, 32'd6, 32'h56EDFABD, 3'b000);
        xact(1'b1, 32'd7, 32'h78ADEFAB, 3'b000);
        xact(1'b0, 32'd4, 32'd0, 3'b010);
        check("t2_lw4", last_rdata, 32'hABBDADEF);

        // Sized stores and sign/zero extension.
        xact(1'b1, 32'd36, 32'h1234ABCD, 3'b010);
        xact(1'b1, 32'd36, 32'h5678EFDA, 3'b001);
        xact(1'b0, 32'd36, 32'd0, 3'b010);
        check("t3_lw36", last_rdata, 32'h1234EFDA);
        xact(1'b0, 32'd36, 32'd0, 3'b001);
        check("t3_lh36", last_rdata, 32'hFFFFEFDA);
        xact(1'b0, 32'd36, 32'd0, 3'b101);
        check("t3_lhu36", last_rdata, 32'h0000EFDA);
        xact(1'b0, 32'd37, 32'd0, 3'b000);
        check("t3_lb37", last_rdata, 32'hFFFFFFEF);
        xact(1'b0, 32'd37, 32'd0, 3'b100);
        check("t3_lbu37", last_rdata, 32'h000000EF);

        // Misalignment.
        xact(1'b0, 32'd5, 32'd0, 3'b010);
        check("t4_lw5_err", {31'd0, last_err}, 32'd1);
        check("t4_lw5_data", last_rdata, 32'd0);
        xact(1'b1, 32'd37, 32'h0000BEEF, 3'b001);
        check("t4_sh37_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'd36, 32'd0, 3'b010);
        check("t4_lw36_kept", last_rdata, 32'h1234EFDA);

        // Range and encoding faults.
        xact(1'b0, 32'(DEPTH - 2), 32'd0, 3'b010);
        check("t5_range_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'(DEPTH - 4), 32'd0, 3'b010);
        check("t5_top_word_ok", {31'd0, last_err}, 32'd0);
        xact(1'b0, 32'd0, 32'd0, 3'b011);
        check("t5_f3_011_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'd8, 32'd0, 3'b010);
        saved = last_rdata;
        xact(1'b1, 32'd8, 32'hFFFFFFFF, 3'b100);
        check("t5_sbu_err", {31'd0, last_err}, 32'd1);
        xact(1'b0, 32'd8, 32'd0, 3'b010);
        check("t5_mem_unchanged", last_rdata, saved);

        // Reset in the middle of a multi-cycle load drops it.
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 32'd4;
        req_funct3  = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        check("t6_busy_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("t6_ready_after_reset", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_late_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xact(1'b0, 32'd4, 32'd0, 3'b010);
        check("t6_lw4_after_reset", last_rdata, 32'hABBDADEF);

        // Randomized mix of loads, stores and faults.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
            xact(1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
